// File: rtl/ttt_multi_processor_if.sv
// rtl/ttt_multi_processor_if.sv - instruction/response bus of the multi-channel token processor
//
// Purpose: bundles the host instruction handshake, the response and the
// per-channel token signals of ttt_multi_processor.
// Ports (signals):
//   instr_valid / instr_ready     instruction handshake
//   instr_bcast                   sweep tally/advance over every channel
//   instruction, channel, data_in opcode, target channel, write data / delta
//   data_out, data_valid          registered response and its 1-cycle strobe
//   token_start, token_stop       per-channel 1-cycle pulses
//   token_active                  per-channel level, countdown nonzero
// Modports: master = host side, slave = processor side.

interface ttt_multi_processor_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int CHAN_BITS    = 2,
  parameter int DATA_BITS    = 8
);
  logic                    instr_valid;
  logic                    instr_ready;
  logic                    instr_bcast;
  logic [3:0]              instruction;
  logic [CHAN_BITS-1:0]    channel;
  logic [DATA_BITS-1:0]    data_in;
  logic [DATA_BITS-1:0]    data_out;
  logic                    data_valid;
  logic [NUM_CHANNELS-1:0] token_start;
  logic [NUM_CHANNELS-1:0] token_stop;
  logic [NUM_CHANNELS-1:0] token_active;

  modport master (
    output instr_valid, instr_bcast, instruction, channel, data_in,
    input  instr_ready, data_out, data_valid, token_start, token_stop, token_active
  );

  modport slave (
    input  instr_valid, instr_bcast, instruction, channel, data_in,
    output instr_ready, data_out, data_valid, token_start, token_stop, token_active
  );
endinterface

// File: rtl/ttt_multi_processor.sv
// rtl/ttt_multi_processor.sv - multi-channel tick-tock-token processor
//
// Purpose: NUM_CHANNELS independent good/bad token accumulators with
// thresholds, durations and countdowns. The host addresses one channel per
// instruction, or broadcasts tally/advance, which is applied to channel
// 0..NUM_CHANNELS-1 one per cycle by a sweep FSM.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   ena    global enable; low freezes all state and blocks acceptance
//   bus    ttt_multi_processor_if.slave (instruction handshake, response,
//          per-channel token_start/token_stop/token_active)
// Timing: an instruction accepted at edge N executes at edge N+1, where the
// state update, data_out/data_valid and token pulses are registered.

module ttt_multi_processor #(
  parameter int NUM_CHANNELS  = 4,
  parameter int CHAN_BITS     = 2,
  parameter int TOKEN_BITS    = 8,
  parameter int DURATION_BITS = 8,
  parameter int DATA_BITS     = 8
) (
  input logic clk,
  input logic rst_n,
  input logic ena,
  ttt_multi_processor_if.slave bus
);

  localparam int CNT_BITS = $clog2(NUM_CHANNELS + 1);
  localparam logic [CHAN_BITS-1:0] LAST_CH = CHAN_BITS'(NUM_CHANNELS - 1);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  // Per-channel state
  logic signed [TOKEN_BITS-1:0]    good_q   [NUM_CHANNELS];
  logic signed [TOKEN_BITS-1:0]    bad_q    [NUM_CHANNELS];
  logic signed [TOKEN_BITS-1:0]    gthr_q   [NUM_CHANNELS];
  logic signed [TOKEN_BITS-1:0]    bthr_q   [NUM_CHANNELS];
  logic        [DURATION_BITS-1:0] dur_q    [NUM_CHANNELS];
  logic        [DURATION_BITS-1:0] remain_q [NUM_CHANNELS];

  // Accepted unicast instruction waiting to execute on the next edge
  logic                 pend_valid_q;
  logic [3:0]           pend_op_q;
  logic [CHAN_BITS-1:0] pend_ch_q;
  logic [DATA_BITS-1:0] pend_data_q;

  // Sweep control
  state_t               state_q, state_d;
  logic [CHAN_BITS-1:0] k_q;
  logic                 sweep_adv_q;
  logic [CNT_BITS-1:0]  cnt_q;

  logic [DATA_BITS-1:0]    data_out_q;
  logic                    data_valid_q;
  logic [NUM_CHANNELS-1:0] start_q, stop_q, active;

  logic busy, accept, bcast_start, sweep_step, sweep_last, op_en;

  assign accept      = bus.instr_valid & ~busy & ena;
  assign bcast_start = accept & bus.instr_bcast & (bus.instruction[3:1] == 3'b100);
  assign sweep_step  = (state_q == S_SWEEP) & ena;
  assign sweep_last  = sweep_step & (k_q == LAST_CH);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      S_IDLE:  if (bcast_start) state_d = S_SWEEP;
      S_SWEEP: begin
        busy = 1'b1;
        if (sweep_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  function automatic logic signed [TOKEN_BITS-1:0] sat_add(
    input logic signed [TOKEN_BITS-1:0] a,
    input logic signed [TOKEN_BITS-1:0] b
  );
    logic [TOKEN_BITS:0] s;
    s = {a[TOKEN_BITS-1], a} + {b[TOKEN_BITS-1], b};
    // Sign bit and carry-out disagree only on overflow; carry-out gives direction
    if (s[TOKEN_BITS] != s[TOKEN_BITS-1])
      return s[TOKEN_BITS] ? {1'b1, {(TOKEN_BITS-1){1'b0}}} : {1'b0, {(TOKEN_BITS-1){1'b1}}};
    return s[TOKEN_BITS-1:0];
  endfunction

  function automatic logic [DATA_BITS-1:0] sext(input logic signed [TOKEN_BITS-1:0] v);
    return DATA_BITS'(v);
  endfunction

  // Execute stage: either the pending unicast op or the current sweep channel
  logic [3:0]                      op_code;
  logic [CHAN_BITS-1:0]            op_ch;
  logic signed [TOKEN_BITS-1:0]    delta;
  logic signed [TOKEN_BITS-1:0]    cur_good, cur_bad, cur_gthr, cur_bthr;
  logic        [DURATION_BITS-1:0] cur_dur, cur_rem;
  logic signed [TOKEN_BITS-1:0]    nxt_good, nxt_bad, nxt_gthr, nxt_bthr;
  logic        [DURATION_BITS-1:0] nxt_dur, nxt_rem;
  logic                            p_start, p_stop, hit;
  logic [DATA_BITS-1:0]            resp;

  assign op_en   = sweep_step | (pend_valid_q & ena);
  assign op_code = sweep_step ? {3'b100, sweep_adv_q} : pend_op_q;
  assign op_ch   = sweep_step ? k_q : pend_ch_q;
  assign delta   = pend_data_q[TOKEN_BITS-1:0];

  always_comb begin
    cur_good = good_q[op_ch];
    cur_bad  = bad_q[op_ch];
    cur_gthr = gthr_q[op_ch];
    cur_bthr = bthr_q[op_ch];
    cur_dur  = dur_q[op_ch];
    cur_rem  = remain_q[op_ch];
    nxt_good = cur_good;
    nxt_bad  = cur_bad;
    nxt_gthr = cur_gthr;
    nxt_bthr = cur_bthr;
    nxt_dur  = cur_dur;
    nxt_rem  = cur_rem;
    p_start  = 1'b0;
    p_stop   = 1'b0;
    resp     = '0;
    case (op_code)
      4'b0000: begin nxt_good = sat_add(cur_good, delta); resp = sext(nxt_good); end
      4'b0001: begin nxt_bad  = sat_add(cur_bad, delta);  resp = sext(nxt_bad);  end
      4'b0010: begin nxt_good = delta; resp = sext(delta); end
      4'b0011: resp = sext(cur_good);
      4'b0100: begin nxt_bad = delta; resp = sext(delta); end
      4'b0101: resp = sext(cur_bad);
      4'b0110: begin
        nxt_rem = pend_data_q[DURATION_BITS-1:0];
        resp    = DATA_BITS'(nxt_rem);
      end
      4'b0111: resp = DATA_BITS'(cur_rem);
      4'b1000: begin
        if (cur_rem == '0 && cur_good >= cur_gthr && cur_bad < cur_bthr) begin
          p_start = 1'b1;
          // A zero-length token starts and stops on the same edge
          p_stop  = (cur_dur == '0);
          nxt_rem = cur_dur;
        end
        nxt_good = '0;
        nxt_bad  = '0;
        resp     = DATA_BITS'({nxt_rem != '0, p_start, p_stop});
      end
      4'b1001: begin
        if (cur_rem != '0) begin
          nxt_rem = cur_rem - DURATION_BITS'(1);
          p_stop  = (cur_rem == DURATION_BITS'(1));
        end
        resp = DATA_BITS'({nxt_rem != '0, p_start, p_stop});
      end
      4'b1010: begin nxt_gthr = delta; resp = sext(delta); end
      4'b1011: resp = sext(cur_gthr);
      4'b1100: begin nxt_bthr = delta; resp = sext(delta); end
      4'b1101: resp = sext(cur_bthr);
      4'b1110: begin
        nxt_dur = pend_data_q[DURATION_BITS-1:0];
        resp    = DATA_BITS'(nxt_dur);
      end
      4'b1111: resp = DATA_BITS'(cur_dur);
      default: resp = '0;
    endcase
  end

  // Sweep tallies count starts, sweep advances count stops
  assign hit = sweep_adv_q ? p_stop : p_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        good_q[i]   <= '0;
        bad_q[i]    <= '0;
        gthr_q[i]   <= '0;
        bthr_q[i]   <= '0;
        dur_q[i]    <= '0;
        remain_q[i] <= '0;
      end
      pend_valid_q <= 1'b0;
      pend_op_q    <= '0;
      pend_ch_q    <= '0;
      pend_data_q  <= '0;
      k_q          <= '0;
      sweep_adv_q  <= 1'b0;
      cnt_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      start_q      <= '0;
      stop_q       <= '0;
    end else begin
      data_valid_q <= 1'b0;
      start_q      <= '0;
      stop_q       <= '0;
      if (ena) begin
        pend_valid_q <= accept & ~bcast_start;
        if (accept) begin
          pend_op_q   <= bus.instruction;
          pend_ch_q   <= bus.channel;
          pend_data_q <= bus.data_in;
        end
        if (bcast_start) begin
          k_q         <= '0;
          cnt_q       <= '0;
          sweep_adv_q <= bus.instruction[0];
        end
        if (op_en) begin
          good_q[op_ch]   <= nxt_good;
          bad_q[op_ch]    <= nxt_bad;
          gthr_q[op_ch]   <= nxt_gthr;
          bthr_q[op_ch]   <= nxt_bthr;
          dur_q[op_ch]    <= nxt_dur;
          remain_q[op_ch] <= nxt_rem;
          start_q[op_ch]  <= p_start;
          stop_q[op_ch]   <= p_stop;
        end
        if (sweep_step) begin
          k_q   <= k_q + CHAN_BITS'(1);
          cnt_q <= cnt_q + CNT_BITS'(hit);
          if (sweep_last) begin
            data_out_q   <= DATA_BITS'(cnt_q + CNT_BITS'(hit));
            data_valid_q <= 1'b1;
          end
        end else if (op_en) begin
          data_out_q   <= resp;
          data_valid_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) active[i] = (remain_q[i] != '0);
  end

  assign bus.instr_ready  = ~busy;
  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.token_start  = start_q;
  assign bus.token_stop   = stop_q;
  assign bus.token_active = active;

endmodule

// File: tb/tb_ttt_multi_processor.sv
// tb/tb_ttt_multi_processor.sv - directed self-checking bench for ttt_multi_processor

module tb_ttt_multi_processor;

  localparam int OP_ADD_GOOD = 4'b0000;
  localparam int OP_SET_GOOD = 4'b0010;
  localparam int OP_GET_GOOD = 4'b0011;
  localparam int OP_GET_REM  = 4'b0111;
  localparam int OP_TALLY    = 4'b1000;
  localparam int OP_ADV      = 4'b1001;
  localparam int OP_SET_GTHR = 4'b1010;
  localparam int OP_GET_GTHR = 4'b1011;
  localparam int OP_SET_BTHR = 4'b1100;
  localparam int OP_SET_DUR  = 4'b1110;
  localparam int OP_GET_DUR  = 4'b1111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;

  always #5 clk = ~clk;

  ttt_multi_processor_if #(.NUM_CHANNELS(4), .CHAN_BITS(2), .DATA_BITS(8)) bus ();

  ttt_multi_processor #(
    .NUM_CHANNELS(4), .CHAN_BITS(2), .TOKEN_BITS(8), .DURATION_BITS(8), .DATA_BITS(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction; returns 1ns after its accept edge
  task automatic issue(input int bc, input int ins, input int ch, input int d);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_bcast = 1'(bc);
    bus.instruction = 4'(ins);
    bus.channel     = 2'(ch);
    bus.data_in     = 8'(d);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr_bcast = 1'b0;
  endtask

  // Unicast op, returns with its response visible
  task automatic uni(input int ins, input int ch, input int d);
    issue(0, ins, ch, d);
    step();
  endtask

  task automatic check_resp(input string tag, input int exp);
    check({tag, "_valid"}, 32'(bus.data_valid), 1);
    check(tag, 32'(bus.data_out), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_bcast = 1'b0;
    bus.instruction = '0;
    bus.channel     = '0;
    bus.data_in     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  32'(bus.instr_ready), 1);
    check("rst_dvalid", 32'(bus.data_valid), 0);
    check("rst_dout",   32'(bus.data_out), 0);
    check("rst_active", 32'(bus.token_active), 0);
    check("rst_start",  32'(bus.token_start), 0);
    check("rst_stop",   32'(bus.token_stop), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Channel 1 single token life cycle
    uni(OP_SET_GTHR, 1, 3);  check_resp("set_gthr", 3);
    uni(OP_SET_BTHR, 1, 2);  check_resp("set_bthr", 2);
    uni(OP_SET_DUR, 1, 2);   check_resp("set_dur", 2);
    uni(OP_ADD_GOOD, 1, 3);  check_resp("add_good", 3);
    uni(OP_TALLY, 1, 0);     check_resp("tally1", 'b110);
    check("tally1_start",  32'(bus.token_start), 'b0010);
    check("tally1_stop",   32'(bus.token_stop), 0);
    check("tally1_active", 32'(bus.token_active), 'b0010);
    step();
    check("start_1cyc",  32'(bus.token_start), 0);
    check("dvalid_1cyc", 32'(bus.data_valid), 0);
    uni(OP_GET_GOOD, 1, 0);  check_resp("good_cleared", 0);
    uni(OP_ADV, 1, 0);       check_resp("adv1", 'b100);
    check("adv1_stop",   32'(bus.token_stop), 0);
    check("adv1_active", 32'(bus.token_active), 'b0010);
    uni(OP_ADV, 1, 0);       check_resp("adv2", 'b001);
    check("adv2_stop",   32'(bus.token_stop), 'b0010);
    check("adv2_active", 32'(bus.token_active), 0);
    uni(OP_ADV, 1, 0);       check_resp("adv3", 0);
    check("adv3_stop",   32'(bus.token_stop), 0);
    check("adv3_active", 32'(bus.token_active), 0);

    // Saturation on channel 0
    uni(OP_ADD_GOOD, 0, 100);   check_resp("sat_add1", 100);
    uni(OP_ADD_GOOD, 0, 100);   check_resp("sat_add2", 'h7f);
    uni(OP_GET_GOOD, 0, 0);     check_resp("sat_max", 'h7f);
    uni(OP_ADD_GOOD, 0, 'h80);  check_resp("sat_sub1", 'hff);
    uni(OP_ADD_GOOD, 0, 'h80);  check_resp("sat_sub2", 'h80);
    uni(OP_GET_GOOD, 0, 0);     check_resp("sat_min", 'h80);

    // Broadcast tally: channels 0 and 2 qualify
    uni(OP_SET_GOOD, 0, 1);
    uni(OP_SET_BTHR, 0, 1);
    uni(OP_SET_DUR, 0, 3);
    uni(OP_SET_BTHR, 2, 1);
    uni(OP_SET_DUR, 2, 1);
    issue(1, OP_TALLY, 0, 0);
    check("bt_ready_a", 32'(bus.instr_ready), 0);
    step();
    check("bt_k0_start", 32'(bus.token_start), 'b0001);
    check("bt_k0_dv",    32'(bus.data_valid), 0);
    check("bt_ready_b",  32'(bus.instr_ready), 0);
    step();
    check("bt_k1_start", 32'(bus.token_start), 0);
    check("bt_ready_c",  32'(bus.instr_ready), 0);
    step();
    check("bt_k2_start", 32'(bus.token_start), 'b0100);
    check("bt_ready_d",  32'(bus.instr_ready), 0);
    step();
    check("bt_k3_start", 32'(bus.token_start), 0);
    check_resp("bt_count", 2);
    check("bt_ready_e",  32'(bus.instr_ready), 1);
    check("bt_active",   32'(bus.token_active), 'b0101);

    // Broadcast advance with an ena stall after channel 0
    issue(1, OP_ADV, 0, 0);
    step();
    check("ba_k0_stop",   32'(bus.token_stop), 0);
    check("ba_k0_active", 32'(bus.token_active), 'b0101);
    ena = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("ba_stall_stop",  32'(bus.token_stop), 0);
      check("ba_stall_dv",    32'(bus.data_valid), 0);
      check("ba_stall_ready", 32'(bus.instr_ready), 0);
    end
    ena = 1'b1;
    step();
    check("ba_k1_stop", 32'(bus.token_stop), 0);
    step();
    check("ba_k2_stop",   32'(bus.token_stop), 'b0100);
    check("ba_k2_active", 32'(bus.token_active), 'b0001);
    step();
    check_resp("ba_count", 1);
    check("ba_ready", 32'(bus.instr_ready), 1);

    // Zero duration: start and stop together, countdown stays idle
    uni(OP_SET_BTHR, 3, 1);
    uni(OP_TALLY, 3, 0);     check_resp("dur0_tally", 'b011);
    check("dur0_start",  32'(bus.token_start), 'b1000);
    check("dur0_stop",   32'(bus.token_stop), 'b1000);
    check("dur0_active", 32'(bus.token_active), 'b0001);

    // Back-to-back same channel: read sees the preceding write
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_bcast = 1'b0;
    bus.instruction = 4'(OP_SET_GOOD);
    bus.channel     = 2'd2;
    bus.data_in     = 8'd5;
    @(negedge clk);
    bus.instruction = 4'(OP_GET_GOOD);
    bus.data_in     = 8'd0;
    step();
    bus.instr_valid = 1'b0;
    check_resp("b2b_set", 5);
    step();
    check_resp("b2b_get", 5);

    // Reset in the middle of a sweep
    issue(1, OP_TALLY, 0, 0);
    step();
    rst_n = 1'b0;
    step();
    check("mrst_ready",  32'(bus.instr_ready), 1);
    check("mrst_dv",     32'(bus.data_valid), 0);
    check("mrst_dout",   32'(bus.data_out), 0);
    check("mrst_active", 32'(bus.token_active), 0);
    check("mrst_start",  32'(bus.token_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mrst_no_start", 32'(bus.token_start), 0);
      check("mrst_no_stop",  32'(bus.token_stop), 0);
      check("mrst_idle_rdy", 32'(bus.instr_ready), 1);
    end
    uni(OP_GET_DUR, 0, 0);   check_resp("mrst_dur0", 0);
    uni(OP_GET_GTHR, 1, 0);  check_resp("mrst_gthr1", 0);
    uni(OP_GET_REM, 0, 0);   check_resp("mrst_rem0", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
